// File: rtl/hazard_forward_unit.sv
// Decode register, FWD_DEPTH-deep destination history, operand-forwarding selects and load-use hold.
// Optional macro HFU_LOAD_STALL_EN: stall only on a true load-use dependency (default: bubble after every load).
module hazard_forward_unit #(
  parameter int INS_W     = 24,
  parameter int OP_W      = 5,
  parameter int RA_W      = 5,
  parameter int IMM_W     = 8,
  parameter int FWD_DEPTH = 3,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INS_W-1:0] ins,
  input  logic             ins_valid,
  output logic             ins_ready,
  output logic [OP_W-1:0]  op_dec,
  output logic [IMM_W-1:0] imm,
  output logic             imm_sel,
  output logic [SEL_W-1:0] mux_sel_a,
  output logic [SEL_W-1:0] mux_sel_b,
  output logic [RA_W-1:0]  rw_dm,
  output logic             mem_en_ex,
  output logic             mem_rw_ex,
  output logic             mem_mux_sel_dm,
  output logic             stall
);

  localparam int RD_LSB = INS_W - OP_W - RA_W;
  localparam int RS_LSB = RD_LSB - RA_W;
  localparam int RT_LSB = RS_LSB - RA_W;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_IMM,
    CL_LD,
    CL_ST,
    CL_JMP,
    CL_CJ
  } ins_class_t;

  // Incoming instruction fields
  logic [OP_W-1:0]  op_in;
  logic [RA_W-1:0]  rd_in;
  logic [RA_W-1:0]  rs_in;
  logic [RA_W-1:0]  rt_in;
  logic [IMM_W-1:0] imm_in;
  ins_class_t       cls_in;
  logic             jump_in;
  logic [RA_W-1:0]  rd_eff;
  logic [RA_W-1:0]  rs_eff;
  logic [RA_W-1:0]  rt_eff;
  logic             wen_in;

  assign op_in  = ins[INS_W-1 -: OP_W];
  assign rd_in  = ins[RD_LSB +: RA_W];
  assign rs_in  = ins[RS_LSB +: RA_W];
  assign rt_in  = ins[RT_LSB +: RA_W];
  assign imm_in = ins[IMM_W:1];

  always_comb begin
    cls_in = CL_ALU;
    if (op_in == OP_W'(5'b11000)) begin
      cls_in = CL_JMP;
    end else if (op_in[OP_W-1 -: 3] == 3'b111) begin
      cls_in = CL_CJ;
    end else if (op_in == OP_W'(5'b10100)) begin
      cls_in = CL_LD;
    end else if (op_in == OP_W'(5'b10101)) begin
      cls_in = CL_ST;
    end else if (op_in[OP_W-1 -: 2] == 2'b01) begin
      cls_in = CL_IMM;
    end
  end

  // Jumps read and write no registers, so their register fields never take part in matching.
  assign jump_in = (cls_in == CL_JMP) || (cls_in == CL_CJ);
  assign rd_eff  = jump_in ? '0 : rd_in;
  assign rs_eff  = jump_in ? '0 : rs_in;
  assign rt_eff  = jump_in ? '0 : rt_in;
  assign wen_in  = !jump_in && (cls_in != CL_ST) && (rd_eff != '0);

  // Decode stage
  logic             dec_valid_reg;
  logic [OP_W-1:0]  dec_op_reg;
  logic [RA_W-1:0]  dec_rd_reg;
  logic [RA_W-1:0]  dec_rs_reg;
  logic [RA_W-1:0]  dec_rt_reg;
  logic [IMM_W-1:0] dec_imm_reg;
  ins_class_t       dec_cls_reg;
  logic             dec_wen_reg;

  logic load_use;
  logic accept;

`ifdef HFU_LOAD_STALL_EN
  assign load_use = dec_valid_reg && (dec_cls_reg == CL_LD) && (dec_rd_reg != '0) && ins_valid &&
                    ((rs_eff == dec_rd_reg) || (rt_eff == dec_rd_reg));
`else
  assign load_use = dec_valid_reg && (dec_cls_reg == CL_LD);
`endif

  assign ins_ready = !reset && !load_use;
  assign stall     = !reset && load_use;
  assign accept    = ins_valid && ins_ready;

  // Anything not accepted this cycle becomes a bubble in decode.
  always_ff @(posedge clk) begin
    if (reset || !accept) begin
      dec_valid_reg <= 1'b0;
      dec_op_reg    <= '0;
      dec_rd_reg    <= '0;
      dec_rs_reg    <= '0;
      dec_rt_reg    <= '0;
      dec_imm_reg   <= '0;
      dec_cls_reg   <= CL_ALU;
      dec_wen_reg   <= 1'b0;
    end else begin
      dec_valid_reg <= 1'b1;
      dec_op_reg    <= op_in;
      dec_rd_reg    <= rd_eff;
      dec_rs_reg    <= rs_eff;
      dec_rt_reg    <= rt_eff;
      dec_imm_reg   <= imm_in;
      dec_cls_reg   <= cls_in;
      dec_wen_reg   <= wen_in;
    end
  end

  // History: index 1 is EX, index 2 is DM, oldest entry falls off the end.
  logic [RA_W-1:0]    hist_addr_reg [1:FWD_DEPTH];
  logic [FWD_DEPTH:1] hist_wen_reg;
  logic [FWD_DEPTH:1] hist_ld_reg;
  logic [FWD_DEPTH:1] hist_st_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        hist_addr_reg[k] <= '0;
      end
      hist_wen_reg <= '0;
      hist_ld_reg  <= '0;
      hist_st_reg  <= '0;
    end else begin
      hist_addr_reg[1] <= dec_rd_reg;
      for (int k = 2; k <= FWD_DEPTH; k++) begin
        hist_addr_reg[k] <= hist_addr_reg[k-1];
      end
      hist_wen_reg <= {hist_wen_reg[FWD_DEPTH-1:1], dec_valid_reg && dec_wen_reg};
      hist_ld_reg  <= {hist_ld_reg[FWD_DEPTH-1:1], dec_valid_reg && (dec_cls_reg == CL_LD)};
      hist_st_reg  <= {hist_st_reg[FWD_DEPTH-1:1], dec_valid_reg && (dec_cls_reg == CL_ST)};
    end
  end

  // Per-stage operand matches; only registered state feeds the selects.
  logic [FWD_DEPTH:1] hit_a;
  logic [FWD_DEPTH:1] hit_b;

  generate
    for (genvar gi = 1; gi <= FWD_DEPTH; gi++) begin : g_match
      assign hit_a[gi] = hist_wen_reg[gi] && (dec_rs_reg != '0) && (hist_addr_reg[gi] == dec_rs_reg);
      assign hit_b[gi] = hist_wen_reg[gi] && (dec_rt_reg != '0) && (hist_addr_reg[gi] == dec_rt_reg);
    end
  endgenerate

  // Scan oldest to youngest so the nearest matching stage overwrites older ones.
  always_comb begin
    mux_sel_a = '0;
    mux_sel_b = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (hit_a[k]) begin
        mux_sel_a = SEL_W'(k);
      end
      if (hit_b[k]) begin
        mux_sel_b = SEL_W'(k);
      end
    end
  end

  assign op_dec         = dec_op_reg;
  assign imm            = dec_imm_reg;
  assign imm_sel        = (dec_cls_reg == CL_IMM);
  assign mem_en_ex      = hist_ld_reg[1] || hist_st_reg[1];
  assign mem_rw_ex      = hist_st_reg[1];
  assign mem_mux_sel_dm = hist_ld_reg[2];
  assign rw_dm          = hist_addr_reg[2];

  logic unused_bits;
  assign unused_bits = ^{ins[0], hist_ld_reg, hist_st_reg};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: vector table, hand sequences and random stimulus vs a pipeline model.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] ins;
  logic        ins_valid;

  logic        ins_ready, imm_sel, mem_en_ex, mem_rw_ex, mem_mux_sel_dm, stall;
  logic [4:0]  op_dec, rw_dm;
  logic [7:0]  imm;
  logic [1:0]  mux_sel_a, mux_sel_b;

  logic        d2_ready, d2_imm_sel, d2_mem_en_ex, d2_mem_rw_ex, d2_mem_mux_sel_dm, d2_stall;
  logic [4:0]  d2_op_dec, d2_rw_dm;
  logic [7:0]  d2_imm;
  logic [1:0]  d2_sel_a, d2_sel_b;

  always #5 clk = ~clk;

  hazard_forward_unit #(.FWD_DEPTH(3)) dut (
    .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .op_dec(op_dec), .imm(imm), .imm_sel(imm_sel), .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b),
    .rw_dm(rw_dm), .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex), .mem_mux_sel_dm(mem_mux_sel_dm),
    .stall(stall)
  );

  hazard_forward_unit #(.FWD_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid), .ins_ready(d2_ready),
    .op_dec(d2_op_dec), .imm(d2_imm), .imm_sel(d2_imm_sel), .mux_sel_a(d2_sel_a), .mux_sel_b(d2_sel_b),
    .rw_dm(d2_rw_dm), .mem_en_ex(d2_mem_en_ex), .mem_rw_ex(d2_mem_rw_ex),
    .mem_mux_sel_dm(d2_mem_mux_sel_dm), .stall(d2_stall)
  );

  int checks = 0;
  int errors = 0;
  logic last_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pipe[0] is the decode stage, pipe[k] is history stage k.
  typedef struct {
    bit       valid;
    bit [4:0] op, rd, rs, rt;
    bit [7:0] imm;
    bit       wen, ld, st, is_imm;
  } rec_t;

  rec_t pipe[$];

  function automatic rec_t bubble();
    rec_t b = '{default: 0};
    return b;
  endfunction

  function automatic rec_t decode_ins(input logic [23:0] i);
    rec_t r = '{default: 0};
    bit jump = 0;
    r.valid = 1;
    r.op = i[23:19]; r.rd = i[18:14]; r.rs = i[13:9]; r.rt = i[8:4]; r.imm = i[8:1];
    casez (r.op)
      5'b11000, 5'b111??: jump = 1;
      5'b10100: r.ld = 1;
      5'b10101: r.st = 1;
      5'b01???: r.is_imm = 1;
      default: ;
    endcase
    if (jump) begin
      r.rd = 0; r.rs = 0; r.rt = 0;
    end
    r.wen = !jump && !r.st && (r.rd != 0);
    return r;
  endfunction

  function automatic void model_reset();
    pipe.delete();
    for (int k = 0; k <= 3; k++) pipe.push_back(bubble());
  endfunction

  function automatic int model_sel(input int depth, input bit [4:0] r);
    for (int k = 1; k <= depth; k++) begin
      if (r != 0 && pipe[k].wen && pipe[k].rd == r) return k;
    end
    return 0;
  endfunction

  function automatic bit model_ready(input logic [23:0] i, input bit v);
    rec_t d = pipe[0];
    rec_t n = decode_ins(i);
`ifdef HFU_LOAD_STALL_EN
    return !(d.valid && d.ld && d.rd != 0 && v && (n.rs == d.rd || n.rt == d.rd));
`else
    return !(d.valid && d.ld) || (v && n.valid && 1'b0);
`endif
  endfunction

  task automatic check_outputs();
    chk("op_dec", op_dec, pipe[0].op);
    chk("imm", imm, pipe[0].imm);
    chk("imm_sel", imm_sel, pipe[0].is_imm);
    chk("mux_sel_a", mux_sel_a, model_sel(3, pipe[0].rs));
    chk("mux_sel_b", mux_sel_b, model_sel(3, pipe[0].rt));
    chk("d2_sel_a", d2_sel_a, model_sel(2, pipe[0].rs));
    chk("d2_sel_b", d2_sel_b, model_sel(2, pipe[0].rt));
    chk("mem_en_ex", mem_en_ex, pipe[1].ld | pipe[1].st);
    chk("mem_rw_ex", mem_rw_ex, pipe[1].st);
    chk("mem_mux_sel_dm", mem_mux_sel_dm, pipe[2].ld);
    chk("rw_dm", rw_dm, pipe[2].rd);
    chk("d2_rw_dm", d2_rw_dm, pipe[2].rd);
  endtask

  // One clock: drive at the falling edge, check ready combinationally, then registered outputs next falling edge.
  task automatic cycle(input logic [23:0] i, input bit v, output bit acc);
    bit er;
    ins = i; ins_valid = v;
    #1;
    er = model_ready(i, v);
    last_ready = ins_ready;
    chk("ins_ready", ins_ready, er);
    chk("stall", stall, !er);
    chk("d2_ready", d2_ready, er);
    acc = v && er;
    @(posedge clk);
    pipe.push_front(acc ? decode_ins(i) : bubble());
    void'(pipe.pop_back());
    @(negedge clk);
    check_outputs();
    $display("txn ins=%h v=%0d rdy=%0d acc=%0d sel_a=%0d sel_b=%0d rw_dm=%0d", i, v, last_ready, acc,
             mux_sel_a, mux_sel_b, rw_dm);
  endtask

  task automatic do_reset();
    reset = 1'b1; ins_valid = 1'b0; ins = '0;
    #1;
    chk("ready_in_reset", ins_ready, 0);
    chk("stall_in_reset", stall, 0);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    chk("ready_in_reset2", ins_ready, 0);
    check_outputs();
    reset = 1'b0;
  endtask

  task automatic send(input logic [23:0] i, output int stalls);
    bit acc = 0;
    stalls = 0;
    for (int t = 0; t < 4; t++) begin
      cycle(i, 1'b1, acc);
      if (acc) break;
      stalls++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got not-accepted expected accepted within 4 cycles");
    end
  endtask

  function automatic logic [23:0] mk(input int op, input int rd, input int rs, input int rt);
    return {op[4:0], rd[4:0], rs[4:0], rt[4:0], 4'b1011};
  endfunction

  function automatic logic [23:0] rand_ins();
    int kind = $urandom_range(0, 7);
    int op;
    case (kind)
      0: op = 20;
      1: op = 21;
      2: op = 24;
      3: op = 28 + $urandom_range(0, 3);
      4, 5: op = 8 + $urandom_range(0, 7);
      default: op = $urandom_range(0, 7);
    endcase
    return mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)) ^ 24'($urandom_range(0, 15));
  endfunction

  typedef struct {
    int op, rd, rs, rt;
    bit v, ready;
    int sel_a, sel_b, sel_a2, mem_en, rw;
  } vec_t;

  function automatic vec_t mv(input int op, input int rd, input int rs, input int rt, input bit v,
                              input bit ready, input int a, input int b, input int a2, input int me,
                              input int rw);
    vec_t x;
    x.op = op; x.rd = rd; x.rs = rs; x.rt = rt; x.v = v; x.ready = ready;
    x.sel_a = a; x.sel_b = b; x.sel_a2 = a2; x.mem_en = me; x.rw = rw;
    return x;
  endfunction

  vec_t tbl[14];

  initial begin
    bit acc;
    bit pending;
    int s1, s2, s3;
    logic [23:0] cur;

    //           op  rd  rs  rt  v rdy  a  b a2 me  rw
    tbl[0]  = mv( 1,  3,  1,  2, 1, 1,  0, 0, 0, 0,  0);
    tbl[1]  = mv( 1,  4,  3,  3, 1, 1,  1, 1, 1, 0,  0);
    tbl[2]  = mv( 1,  5,  0,  0, 1, 1,  0, 0, 0, 0,  3);
    tbl[3]  = mv( 1,  6,  9, 10, 1, 1,  0, 0, 0, 0,  4);
    tbl[4]  = mv( 1,  7, 11, 12, 1, 1,  0, 0, 0, 0,  5);
    tbl[5]  = mv( 1,  8,  5,  4, 1, 1,  3, 0, 0, 0,  6);
    tbl[6]  = mv( 0,  0,  0,  0, 0, 1,  0, 0, 0, 0,  7);
    tbl[7]  = mv( 1,  0,  1,  2, 1, 1,  0, 0, 0, 0,  8);
    tbl[8]  = mv( 1,  9,  0,  0, 1, 1,  0, 0, 0, 0,  0);
    tbl[9]  = mv(21, 10,  1,  2, 1, 1,  0, 0, 0, 0,  0);
    tbl[10] = mv( 1, 11, 10, 10, 1, 1,  0, 0, 0, 1,  9);
    tbl[11] = mv( 0,  0,  0,  0, 0, 1,  0, 0, 0, 0, 10);
    tbl[12] = mv(24, 11, 11, 11, 1, 1,  0, 0, 0, 0, 11);
    tbl[13] = mv(10, 12, 11,  3, 1, 1,  3, 0, 0, 0,  0);

    reset = 1'b1; ins_valid = 1'b0; ins = '0;
    @(negedge clk);

    // Idle after reset
    do_reset();
    for (int n = 0; n < 3; n++) begin
      cycle(24'h0, 1'b0, acc);
      chk("idle_ready", last_ready, 1);
      chk("idle_sel_a", mux_sel_a, 0);
      chk("idle_mem_en", mem_en_ex, 0);
    end

    // Vector table
    do_reset();
    for (int n = 0; n < 14; n++) begin
      cycle(mk(tbl[n].op, tbl[n].rd, tbl[n].rs, tbl[n].rt), tbl[n].v, acc);
      chk($sformatf("t%0d_ready", n), last_ready, tbl[n].ready);
      chk($sformatf("t%0d_sel_a", n), mux_sel_a, tbl[n].sel_a);
      chk($sformatf("t%0d_sel_b", n), mux_sel_b, tbl[n].sel_b);
      chk($sformatf("t%0d_d2_sel_a", n), d2_sel_a, tbl[n].sel_a2);
      chk($sformatf("t%0d_mem_en", n), mem_en_ex, tbl[n].mem_en);
      chk($sformatf("t%0d_rw_dm", n), rw_dm, tbl[n].rw);
    end

    // Load-use on a dependent consumer
    do_reset();
    cycle(mk(20, 6, 1, 2), 1'b1, acc);
    cycle(mk(1, 8, 6, 3), 1'b1, acc);
    chk("lu_dep_ready", last_ready, 0);
    cycle(mk(1, 8, 6, 3), 1'b1, acc);
    chk("lu_dep_retry_ready", last_ready, 1);
    chk("lu_fwd_a", mux_sel_a, 2);

    // Load followed by an independent instruction
    do_reset();
    cycle(mk(20, 6, 1, 2), 1'b1, acc);
    cycle(mk(1, 8, 1, 2), 1'b1, acc);
`ifdef HFU_LOAD_STALL_EN
    chk("lu_indep_ready", last_ready, 1);
`else
    chk("lu_indep_ready", last_ready, 0);
`endif

    // Load memory-stage timing with a jump in between
    do_reset();
    cycle(mk(20, 7, 1, 2), 1'b1, acc);
    cycle(mk(24, 7, 7, 7), 1'b1, acc);
    chk("ld_mem_en_t2", mem_en_ex, 1);
    chk("ld_mem_rw_t2", mem_rw_ex, 0);
    if (acc) begin
      chk("jmp_nofwd_a", mux_sel_a, 0);
      chk("jmp_nofwd_b", mux_sel_b, 0);
      cycle(24'h0, 1'b0, acc);
    end else begin
      cycle(mk(24, 7, 7, 7), 1'b1, acc);
      chk("jmp_nofwd_a", mux_sel_a, 0);
      chk("jmp_nofwd_b", mux_sel_b, 0);
    end
    chk("ld_dm_sel_t3", mem_mux_sel_dm, 1);
    chk("ld_rw_dm_t3", rw_dm, 7);

    // Back-to-back dependent loads stall once each
    do_reset();
    send(mk(20, 6, 1, 2), s1);
    send(mk(20, 7, 6, 3), s2);
    send(mk(1, 8, 7, 7), s3);
    chk("b2b_ld1_stalls", s1, 0);
    chk("b2b_ld2_stalls", s2, 1);
    chk("b2b_use_stalls", s3, 1);

    // Reset asserted while stalled
    do_reset();
    cycle(mk(20, 6, 1, 2), 1'b1, acc);
    ins = mk(1, 8, 6, 6); ins_valid = 1'b1;
    #1;
    chk("mid_stall_before", stall, 1);
    reset = 1'b1;
    #1;
    chk("mid_stall_reset_stall", stall, 0);
    chk("mid_stall_reset_ready", ins_ready, 0);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_stall_cleared", ins_ready, 1);
    @(negedge clk);
    cycle(mk(1, 8, 6, 6), 1'b1, acc);

    // Random traffic; a stalled instruction is held until accepted
    do_reset();
    cur = rand_ins();
    pending = 0;
    for (int n = 0; n < 400; n++) begin
      bit v;
      if (n == 200) begin
        do_reset();
        pending = 0;
      end
      v = pending ? 1'b1 : ($urandom_range(0, 3) != 0);
      cycle(cur, v, acc);
      pending = v && !acc;
      if (!pending) cur = rand_ins();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
